// File: rtl/axi4_lite_beat_master_if.sv
// AXI4 bus bundle (AXI_BUS) with Master and Slave modports.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 8,
    parameter int unsigned AXI_USER_WIDTH = 8
);
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic                        aw_lock;
    logic [3:0]                  aw_cache;
    logic [2:0]                  aw_prot;
    logic [3:0]                  aw_qos;
    logic [3:0]                  aw_region;
    logic [5:0]                  aw_atop;
    logic [AXI_USER_WIDTH-1:0]   aw_user;
    logic                        aw_valid;
    logic                        aw_ready;

    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic [AXI_USER_WIDTH-1:0]   w_user;
    logic                        w_valid;
    logic                        w_ready;

    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic [1:0]                  b_resp;
    logic [AXI_USER_WIDTH-1:0]   b_user;
    logic                        b_valid;
    logic                        b_ready;

    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic                        ar_lock;
    logic [3:0]                  ar_cache;
    logic [2:0]                  ar_prot;
    logic [3:0]                  ar_qos;
    logic [3:0]                  ar_region;
    logic [AXI_USER_WIDTH-1:0]   ar_user;
    logic                        ar_valid;
    logic                        ar_ready;

    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic [AXI_USER_WIDTH-1:0]   r_user;
    logic                        r_valid;
    logic                        r_ready;

    modport Master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_atop, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/axi4_lite_beat_master.sv
// Single-outstanding, single-beat AXI4 initiator behind a cmd/rsp handshake.
// Optional watchdog flag enabled by defining AXI4M_TIMEOUT_EN.
module axi4_lite_beat_master #(
    parameter int unsigned AXI_ADDR_WIDTH = 32,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned AXI_ID_WIDTH   = 8,
    parameter int unsigned AXI_USER_WIDTH = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        cmd_valid_i,
    output logic                        cmd_ready_o,
    input  logic                        cmd_we_i,
    input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [AXI_DATA_WIDTH/8-1:0] cmd_strb_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic [1:0]                  rsp_resp_o,
    output logic                        rsp_we_o,
    output logic                        timeout_o,
    AXI_BUS.Master                      AXI4_master
);
    localparam logic [2:0] BEAT_SIZE = 3'($clog2(AXI_DATA_WIDTH / 8));

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, RSP} state_e;

    state_e                      state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [AXI_DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [AXI_DATA_WIDTH/8-1:0] strb_q, strb_d;
    logic                        we_q, we_d;
    logic                        aw_valid_q, aw_valid_d;
    logic                        w_valid_q, w_valid_d;
    logic                        b_ready_q, b_ready_d;
    logic                        ar_valid_q, ar_valid_d;
    logic                        r_ready_q, r_ready_d;
    logic [AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]                  resp_q, resp_d;

    logic cmd_fire;
    logic aw_done;
    logic w_done;

    assign cmd_fire = cmd_valid_i && (state_q == IDLE);
    // A channel is done once its valid has dropped or it handshakes this cycle.
    assign aw_done  = !aw_valid_q || AXI4_master.aw_ready;
    assign w_done   = !w_valid_q || AXI4_master.w_ready;

    // NOTE: every variable gets its hold value first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        strb_d     = strb_q;
        we_d       = we_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        b_ready_d  = b_ready_q;
        ar_valid_d = ar_valid_q;
        r_ready_d  = r_ready_q;
        rdata_d    = rdata_q;
        resp_d     = resp_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_wdata_i;
                    strb_d  = cmd_strb_i;
                    we_d    = cmd_we_i;
                    if (cmd_we_i) begin
                        state_d    = WR;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = RD_AR;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            WR: begin
                if (aw_valid_q && AXI4_master.aw_ready) aw_valid_d = 1'b0;
                if (w_valid_q && AXI4_master.w_ready)   w_valid_d  = 1'b0;
                if (aw_done && w_done) begin
                    state_d   = WR_B;
                    b_ready_d = 1'b1;
                end
            end
            WR_B: begin
                if (AXI4_master.b_valid) begin
                    state_d   = RSP;
                    b_ready_d = 1'b0;
                    resp_d    = AXI4_master.b_resp;
                    rdata_d   = '0;
                end
            end
            RD_AR: begin
                if (AXI4_master.ar_ready) begin
                    state_d    = RD_R;
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                end
            end
            RD_R: begin
                if (AXI4_master.r_valid) begin
                    state_d   = RSP;
                    r_ready_d = 1'b0;
                    resp_d    = AXI4_master.r_resp;
                    rdata_d   = AXI4_master.r_data;
                end
            end
            RSP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            we_q       <= 1'b0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            b_ready_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            r_ready_q  <= 1'b0;
            rdata_q    <= '0;
            resp_q     <= 2'b00;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            strb_q     <= strb_d;
            we_q       <= we_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            b_ready_q  <= b_ready_d;
            ar_valid_q <= ar_valid_d;
            r_ready_q  <= r_ready_d;
            rdata_q    <= rdata_d;
            resp_q     <= resp_d;
        end
    end

`ifdef AXI4M_TIMEOUT_EN
    logic [31:0] wd_cnt_q;
    logic        timeout_q;
    logic        busy;

    assign busy = (state_q == WR) || (state_q == WR_B) || (state_q == RD_AR) || (state_q == RD_R);

    // The flag rises on the same edge the counter reaches the limit.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (cmd_fire) begin
                wd_cnt_q <= '0;
            end else if (busy && (wd_cnt_q != '1)) begin
                wd_cnt_q <= wd_cnt_q + 32'd1;
            end
            if (busy && (wd_cnt_q >= 32'(TIMEOUT_CYCLES - 1))) timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign cmd_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RSP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_resp_o  = resp_q;
    assign rsp_we_o    = we_q;

    assign AXI4_master.aw_id     = '0;
    assign AXI4_master.aw_addr   = addr_q;
    assign AXI4_master.aw_len    = 8'd0;
    assign AXI4_master.aw_size   = BEAT_SIZE;
    assign AXI4_master.aw_burst  = 2'b01;
    assign AXI4_master.aw_lock   = 1'b0;
    assign AXI4_master.aw_cache  = 4'd0;
    assign AXI4_master.aw_prot   = 3'd0;
    assign AXI4_master.aw_qos    = 4'd0;
    assign AXI4_master.aw_region = 4'd0;
    assign AXI4_master.aw_atop   = 6'd0;
    assign AXI4_master.aw_user   = '0;
    assign AXI4_master.aw_valid  = aw_valid_q;

    assign AXI4_master.w_data    = wdata_q;
    assign AXI4_master.w_strb    = strb_q;
    assign AXI4_master.w_last    = 1'b1;
    assign AXI4_master.w_user    = '0;
    assign AXI4_master.w_valid   = w_valid_q;

    assign AXI4_master.b_ready   = b_ready_q;

    assign AXI4_master.ar_id     = '0;
    assign AXI4_master.ar_addr   = addr_q;
    assign AXI4_master.ar_len    = 8'd0;
    assign AXI4_master.ar_size   = BEAT_SIZE;
    assign AXI4_master.ar_burst  = 2'b01;
    assign AXI4_master.ar_lock   = 1'b0;
    assign AXI4_master.ar_cache  = 4'd0;
    assign AXI4_master.ar_prot   = 3'd0;
    assign AXI4_master.ar_qos    = 4'd0;
    assign AXI4_master.ar_region = 4'd0;
    assign AXI4_master.ar_user   = '0;
    assign AXI4_master.ar_valid  = ar_valid_q;

    assign AXI4_master.r_ready   = r_ready_q;
endmodule

// File: tb/tb_axi4_lite_beat_master.sv
// Directed, table-driven bench for axi4_lite_beat_master with a cycle-stepped slave.
module tb_axi4_lite_beat_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_we;
    logic        timeout;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int BUDGET = 100;

    AXI_BUS #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(8), .AXI_USER_WIDTH(8)) axi ();

    axi4_lite_beat_master #(
        .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32), .AXI_ID_WIDTH(8),
        .AXI_USER_WIDTH(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk_i(clk), .reset_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_strb_i(cmd_strb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_resp_o(rsp_resp), .rsp_we_o(rsp_we), .timeout_o(timeout),
        .AXI4_master(axi)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          aw_wait, w_wait, b_wait, ar_wait, r_wait, rsp_hold;
        logic [1:0]  slv_resp;
        logic [31:0] slv_rdata;
        int          exp_lat;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic slave_idle();
        axi.aw_ready = 1'b0; axi.w_ready = 1'b0; axi.ar_ready = 1'b0;
        axi.b_valid = 1'b0; axi.b_resp = 2'b00; axi.b_id = '0; axi.b_user = '0;
        axi.r_valid = 1'b0; axi.r_resp = 2'b00; axi.r_data = '0; axi.r_last = 1'b0;
        axi.r_id = '0; axi.r_user = '0;
    endtask

    // Called at a negedge; issues one command and plays the slave until the response is taken.
    task automatic run_txn(input vec_t v, output int lat, output logic [1:0] resp,
                           output logic [31:0] rdata, output logic we,
                           output int errs, output int to_cyc);
        bit aw_done = 0, w_done = 0, ar_done = 0, b_taken = 0, r_taken = 0;
        bit aw_rdy = 0, w_rdy = 0, ar_rdy = 0, bv = 0, rv = 0, b_fire = 0, r_fire = 0;
        bit got = 0, fin = 0;
        int aw_seen = 0, w_seen = 0, ar_seen = 0, b_cnt = 0, r_cnt = 0, hold = 0;
        lat = -1; resp = 2'b00; rdata = '0; we = 1'b0; errs = 0; to_cyc = 0;
        cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_strb = v.strb;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= BUDGET && !fin; cyc++) begin
            if (aw_rdy) begin aw_done = 1; aw_rdy = 0; end
            if (w_rdy)  begin w_done = 1;  w_rdy = 0;  end
            if (ar_rdy) begin ar_done = 1; ar_rdy = 0; end
            if (b_fire) begin b_taken = 1; bv = 0; end
            if (r_fire) begin r_taken = 1; rv = 0; end

            if (cyc == 1 && (v.we ? !(axi.aw_valid && axi.w_valid) : !axi.ar_valid)) errs++;
            if (aw_done && axi.aw_valid) errs++;
            if (w_done && axi.w_valid) errs++;
            if (ar_done && axi.ar_valid) errs++;
            if (b_taken && axi.b_ready) errs++;
            if (r_taken && axi.r_ready) errs++;
            if (v.we ? axi.ar_valid : (axi.aw_valid || axi.w_valid)) errs++;
            if (axi.aw_valid && (axi.aw_addr !== v.addr || axi.aw_len !== 8'd0 || axi.aw_size !== 3'd2 ||
                axi.aw_burst !== 2'b01 || axi.aw_id !== 8'd0 || axi.aw_lock !== 1'b0 ||
                axi.aw_cache !== 4'd0 || axi.aw_prot !== 3'd0 || axi.aw_qos !== 4'd0 ||
                axi.aw_region !== 4'd0 || axi.aw_atop !== 6'd0 || axi.aw_user !== 8'd0)) errs++;
            if (axi.w_valid && (axi.w_data !== v.wdata || axi.w_strb !== v.strb ||
                axi.w_last !== 1'b1 || axi.w_user !== 8'd0)) errs++;
            if (axi.ar_valid && (axi.ar_addr !== v.addr || axi.ar_len !== 8'd0 || axi.ar_size !== 3'd2 ||
                axi.ar_burst !== 2'b01 || axi.ar_id !== 8'd0 || axi.ar_prot !== 3'd0 ||
                axi.ar_cache !== 4'd0 || axi.ar_user !== 8'd0)) errs++;
            if (timeout === 1'b1 && to_cyc == 0) to_cyc = cyc;

            if (axi.aw_valid && !aw_done) begin aw_seen++; aw_rdy = (aw_seen > v.aw_wait); end
            if (axi.w_valid && !w_done)   begin w_seen++;  w_rdy  = (w_seen > v.w_wait);   end
            if (axi.ar_valid && !ar_done) begin ar_seen++; ar_rdy = (ar_seen > v.ar_wait); end
            axi.aw_ready = aw_rdy; axi.w_ready = w_rdy; axi.ar_ready = ar_rdy;

            if (aw_done && w_done && !b_taken) begin
                if (b_cnt >= v.b_wait) bv = 1; else b_cnt++;
            end
            if (ar_done && !r_taken) begin
                if (r_cnt >= v.r_wait) rv = 1; else r_cnt++;
            end
            axi.b_valid = bv; axi.b_resp = bv ? v.slv_resp : 2'b00;
            axi.r_valid = rv; axi.r_resp = rv ? v.slv_resp : 2'b00;
            axi.r_data = rv ? v.slv_rdata : 32'h0; axi.r_last = rv;
            b_fire = bv && axi.b_ready;
            r_fire = rv && axi.r_ready;

            if (rsp_valid) begin
                if (!got) begin
                    got = 1; lat = cyc; resp = rsp_resp; rdata = rsp_rdata; we = rsp_we;
                end else if (rsp_resp !== resp || rsp_rdata !== rdata || rsp_we !== we) begin
                    errs++;
                end
                if (cmd_ready) errs++;
                if (hold >= v.rsp_hold) begin rsp_ready = 1'b1; fin = 1; end
                else hold++;
            end else if (got) begin
                errs++;
            end
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        slave_idle();
        if (!fin) $display("FAIL txn_budget: no response within %0d cycles", BUDGET);
    endtask

    vec_t vecs[7];
    vec_t v;
    int lat, errs, to_cyc;
    logic [1:0]  g_resp;
    logic [31:0] g_rdata;
    logic        g_we;

    initial begin
        //          we    addr          wdata         strb   aw w  b  ar r  hold resp   rdata         lat resp   rdata
        vecs[0] = '{1'b1, 32'h7100_000C, 32'hDEAD_DEAD, 4'hF, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0,        3, 2'b00, 32'h0};
        vecs[1] = '{1'b0, 32'h7100_0010, 32'h0,         4'h0, 0, 0, 0, 0, 4, 0, 2'b00, 32'h0000_00A5, 7, 2'b00, 32'h0000_00A5};
        vecs[2] = '{1'b1, 32'h7100_0014, 32'hCAFE_F00D, 4'hF, 0, 3, 0, 0, 0, 0, 2'b00, 32'h0,        6, 2'b00, 32'h0};
        vecs[3] = '{1'b1, 32'h7100_0018, 32'h0123_4567, 4'hF, 0, 0, 0, 0, 0, 5, 2'b10, 32'h0,        3, 2'b10, 32'h0};
        vecs[4] = '{1'b0, 32'h7100_001C, 32'h0,         4'h0, 0, 0, 0, 2, 0, 0, 2'b11, 32'h1234_5678, 5, 2'b11, 32'h1234_5678};
        vecs[5] = '{1'b1, 32'h7100_0020, 32'hA5A5_A5A5, 4'h3, 2, 0, 2, 0, 0, 0, 2'b00, 32'h0,        7, 2'b00, 32'h0};
        vecs[6] = '{1'b0, 32'h7100_0024, 32'h0,         4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 32'hFFFF_0000, 3, 2'b00, 32'hFFFF_0000};

        slave_idle();
        repeat (2) @(negedge clk);
        check("reset_cmd_ready", cmd_ready, 1);
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_valids", {axi.aw_valid, axi.w_valid, axi.ar_valid, axi.b_ready, axi.r_ready}, 0);
        check("reset_rsp_data", {rsp_resp, rsp_rdata}, 0);
        check("reset_timeout", timeout, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            check($sformatf("cmd_ready[%0d]", i), cmd_ready, 1);
            run_txn(vecs[i], lat, g_resp, g_rdata, g_we, errs, to_cyc);
            check($sformatf("latency[%0d]", i), lat, vecs[i].exp_lat);
            check($sformatf("resp[%0d]", i), g_resp, vecs[i].exp_resp);
            check($sformatf("rdata[%0d]", i), g_rdata, vecs[i].exp_rdata);
            check($sformatf("we[%0d]", i), g_we, vecs[i].we);
            check($sformatf("protocol[%0d]", i), errs, 0);
        end

        // Reset pulse while waiting for read data.
        cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 32'h7100_0028;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("mid_ar_valid", axi.ar_valid, 1);
        axi.ar_ready = 1'b1;
        @(negedge clk);
        axi.ar_ready = 1'b0;
        check("mid_in_rd_r", {axi.r_ready, cmd_ready}, 2'b10);
        #2 rst_n = 1'b0;
        #1;
        check("async_r_ready", axi.r_ready, 0);
        check("async_cmd_ready", cmd_ready, 1);
        check("async_rsp", {rsp_valid, rsp_resp, rsp_rdata}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        v = '{1'b0, 32'h7100_0010, 32'h0, 4'h0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0000_00A5, 3, 2'b00, 32'h0000_00A5};
        run_txn(v, lat, g_resp, g_rdata, g_we, errs, to_cyc);
        check("post_reset_latency", lat, 3);
        check("post_reset_rdata", g_rdata, 32'h0000_00A5);
        check("post_reset_protocol", errs, 0);

        // Long AW stall: watchdog rises after 16 busy cycles when enabled.
        v = '{1'b1, 32'h7100_002C, 32'h5555_AAAA, 4'hF, 20, 0, 0, 0, 0, 0, 2'b00, 32'h0, 23, 2'b00, 32'h0};
        run_txn(v, lat, g_resp, g_rdata, g_we, errs, to_cyc);
        check("stall_latency", lat, 23);
        check("stall_protocol", errs, 0);
`ifdef AXI4M_TIMEOUT_EN
        check("timeout_rise_cycle", to_cyc, 17);
        check("timeout_sticky", timeout, 1);
`else
        check("timeout_rise_cycle", to_cyc, 0);
        check("timeout_tied_low", timeout, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end
endmodule
